// File: rtl/mic_pkg.sv
// Shared constants for the microphone sample path: sample width, FIFO depth,
// timestamp width, and the pointer-width helper used by the sample FIFO.
package mic_pkg;

  localparam int SAMPLE_W   = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int TS_W       = 32;

  // Pointers carry one extra wrap bit above the address so full and empty
  // can be told apart when the addresses match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mic_fifo_mem.sv
// Simple dual-port sample memory: synchronous write, synchronous registered
// read. The read register holds its value between reads and is cleared by
// rst; the storage array itself is never cleared.
module mic_fifo_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Array write; no reset so the storage maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read. A same-address write in the same cycle returns the old
  // word, which is what the full-FIFO read+write case relies on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mic_sample_fifo.sv
// Sample FIFO between the decimating filter and the processor-side reader.
// Registered level/empty/full, sticky overflow on dropped samples, flush via
// clr. Optional feature: define MIC_FIFO_TIMESTAMP_EN to store a free-running
// cycle count with every sample and present it on rd_ts alongside rd_data.
module mic_sample_fifo
  import mic_pkg::*;
#(
  parameter int DW    = SAMPLE_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            data_in,
  input  logic                     data_in_valid,
  input  logic                     clr,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [ptr_w(DEPTH)-1:0]  level,
`ifdef MIC_FIFO_TIMESTAMP_EN
  output logic [TS_W-1:0]          rd_ts,
`endif
  output logic                     overflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
`ifdef MIC_FIFO_TIMESTAMP_EN
  localparam int MW = DW + TS_W;
`else
  localparam int MW = DW;
`endif

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic          rd_accept, wr_accept, drop;
  logic          mem_we, mem_re;
  logic [MW-1:0] mem_wdata, mem_rdata;

  // Accept/drop decisions; a same-cycle read frees the slot for a write.
  always_comb begin
    rd_accept  = rd_en && !empty;
    wr_accept  = data_in_valid && (!full || rd_accept);
    drop       = data_in_valid && full && !rd_accept;
    wr_ptr_nxt = wr_accept ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_nxt = rd_accept ? rd_ptr + PW'(1) : rd_ptr;
    mem_we     = wr_accept && !clr;
    mem_re     = rd_accept && !clr;
  end

  // Pointers, occupancy flags and read strobe; clr outranks any traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      level    <= wr_ptr_nxt - rd_ptr_nxt;
      empty    <= (wr_ptr_nxt == rd_ptr_nxt);
      full     <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                  (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]);
      overflow <= overflow || drop;
      rd_valid <= rd_accept;
    end
  end

`ifdef MIC_FIFO_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running cycle counter; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + TS_W'(1);
  end

  assign mem_wdata = {ts_cnt, data_in};
  assign rd_ts     = mem_rdata[MW-1:DW];
`else
  assign mem_wdata = data_in;
`endif

  assign rd_data = mem_rdata[DW-1:0];

  mic_fifo_mem #(
    .W     (MW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_mic_sample_fifo.sv
// Bench for mic_sample_fifo: directed stimulus, expected read data queued at
// issue time and checked by an independent monitor on every rd_valid.
module tb_mic_sample_fifo;
  import mic_pkg::*;

  localparam int DW = SAMPLE_W;
  localparam int D  = FIFO_DEPTH;
  localparam int PW = ptr_w(D);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          clr = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, empty, full, overflow;
  logic [PW-1:0] level;
`ifdef MIC_FIFO_TIMESTAMP_EN
  logic [TS_W-1:0] rd_ts;
  logic [TS_W-1:0] tcnt;
  logic [TS_W-1:0] exp_ts [$];
`endif

  logic [DW-1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mic_sample_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .clr           (clr),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .empty         (empty),
    .full          (full),
    .level         (level),
`ifdef MIC_FIFO_TIMESTAMP_EN
    .rd_ts         (rd_ts),
`endif
    .overflow      (overflow)
  );

`ifdef MIC_FIFO_TIMESTAMP_EN
  always @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else     tcnt <= tcnt + 1;
  end
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid pops one expected sample.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd_valid", 64'(rd_data), 64'hDEAD_0000_0000);
      end else begin
        chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
`ifdef MIC_FIFO_TIMESTAMP_EN
        if (exp_ts.size() != 0) chk("rd_ts", 64'(rd_ts), 64'(exp_ts.pop_front()));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    data_in_valid = v;
    data_in       = d;
    rd_en         = r;
    clr           = c;
    tick();
    data_in_valid = 1'b0;
    rd_en         = 1'b0;
    clr           = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [DW-1:0] exp);
    exp_q.push_back(exp);
    cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Five samples in, five out in order
    for (int i = 0; i < 5; i++) wr(32'h11 + i);
    chk("t1_level5", 64'(level), 64'd5);
    for (int i = 0; i < 5; i++) begin
      rd(32'h11 + i);
      chk("t1_level_dec", 64'(level), 64'(4 - i));
    end
    tick();
    chk("t1_empty", 64'(empty), 64'd1);

    // Seventeen writes: last one dropped, overflow sticky
    for (int i = 0; i < 16; i++) wr(32'h100 + i);
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_ovf_before", 64'(overflow), 64'd0);
    wr(32'h1FF);
    chk("t2_level16", 64'(level), 64'd16);
    chk("t2_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 16; i++) rd(32'h100 + i);
    tick();
    chk("t2_empty", 64'(empty), 64'd1);
    chk("t2_ovf_sticky", 64'(overflow), 64'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t2_ovf_clr", 64'(overflow), 64'd0);

    // Full FIFO, simultaneous write and read
    for (int i = 0; i < 16; i++) wr(32'h200 + i);
    exp_q.push_back(32'h200);
    cyc(1'b1, 32'hAA, 1'b1, 1'b0);
    chk("t3_level16", 64'(level), 64'd16);
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_overflow", 64'(overflow), 64'd0);
    for (int i = 1; i < 16; i++) rd(32'h200 + i);
    rd(32'hAA);
    tick();
    chk("t3_empty", 64'(empty), 64'd1);

    // Read while empty is ignored; write+read on empty writes only
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t4_rdv_low", 64'(rd_valid), 64'd0);
    chk("t4_level0", 64'(level), 64'd0);
    cyc(1'b1, 32'h7, 1'b1, 1'b0);
    chk("t4_level1", 64'(level), 64'd1);
    chk("t4_rdv_low2", 64'(rd_valid), 64'd0);
    rd(32'h7);
    tick();

    // clr beats a same-cycle write at level 8 with overflow set
    for (int i = 0; i < 16; i++) wr(32'h300 + i);
    wr(32'h3FF);
    for (int i = 0; i < 8; i++) rd(32'h300 + i);
    chk("t5_level8", 64'(level), 64'd8);
    chk("t5_ovf_set", 64'(overflow), 64'd1);
    cyc(1'b1, 32'h3EE, 1'b0, 1'b1);
    chk("t5_level0", 64'(level), 64'd0);
    chk("t5_empty", 64'(empty), 64'd1);
    chk("t5_ovf_clr", 64'(overflow), 64'd0);
    chk("t5_rdv_low", 64'(rd_valid), 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t5_nothing_stored", 64'(rd_valid), 64'd0);
    wr(32'h55);
    rd(32'h55);
    tick();

    // Asynchronous reset mid-stream with a read pending
    wr(32'h61);
    wr(32'h62);
    wr(32'h63);
    rd_en = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("t6_level0", 64'(level), 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_rdv_low", 64'(rd_valid), 64'd0);
    chk("t6_rd_data0", 64'(rd_data), 64'd0);
    rd_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    chk("t6_rdv_after", 64'(rd_valid), 64'd0);
    chk("t6_level_after", 64'(level), 64'd0);
    wr(32'h71);
    rd(32'h71);
    tick();

`ifdef MIC_FIFO_TIMESTAMP_EN
    // Timestamps captured at write time come back with their samples
    begin
      int guard = 0;
      while (tcnt != 100 && guard < 400) begin tick(); guard++; end
      chk("ts_reach100", 64'(tcnt), 64'd100);
      wr(32'hA1);
      guard = 0;
      while (tcnt != 150 && guard < 400) begin tick(); guard++; end
      chk("ts_reach150", 64'(tcnt), 64'd150);
      wr(32'hA2);
      exp_ts.push_back(32'd100);
      rd(32'hA1);
      exp_ts.push_back(32'd150);
      rd(32'hA2);
      tick();
    end
`endif

    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
